// File: rtl/fluxo_dados_rodadas.sv
// Round engine for the MindFocus game: LFSR target draw, release/press/timeout wait, scoring.
// Optional macro SEM_REPETICAO_EN rejects a target equal to the previous round's target.
module fluxo_dados_rodadas #(
    parameter int N_BOTOES = 4,
    parameter int RODADAS  = 3,
    parameter int TIMEOUT  = 50000,
    parameter int IW       = $clog2(N_BOTOES),
    parameter int CW       = $clog2(RODADAS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] alvo,
    output logic                alvo_valido,
    output logic [CW-1:0]       rodada,
    output logic [CW-1:0]       acertos,
    output logic [CW-1:0]       erros,
    output logic [CW-1:0]       timeouts,
    output logic                jogada_feita,
    output logic                acerto_pulso,
    output logic                pronto,
    output logic [2:0]          db_estado,
    output logic [15:0]         db_lfsr
);

    localparam int          TW    = $clog2(TIMEOUT);
    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [IW:0] N_LIM = (IW + 1)'(N_BOTOES);

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        SORTEIA       = 3'd1,
        ESPERA_SOLTA  = 3'd2,
        ESPERA_JOGADA = 3'd3,
        AVALIA        = 3'd4,
        FIM           = 3'd5
    } estado_t;

    estado_t               estado_reg, estado_next;
    logic [15:0]           livre_reg;
    logic [15:0]           lfsr_reg;
    logic [N_BOTOES-1:0]   botoes_reg;
    logic [N_BOTOES-1:0]   alvo_reg;
    logic [N_BOTOES-1:0]   jogada_reg;
    logic                  tipo_press_reg;
    logic [TW-1:0]         tempo_reg;
    logic [CW-1:0]         rodada_reg, acertos_reg, erros_reg, timeouts_reg;

    // Strobes from the FSM to the datapath
    logic carrega_semente, avanca_lfsr, aceita, limpa_tempo, conta_tempo;
    logic captura_jogada, marca_timeout, pontua;

    logic [15:0]         lfsr_passo;
    logic [15:0]         semente;
    logic [IW-1:0]       cand;
    logic [N_BOTOES-1:0] cand_onehot;
    logic                cand_no_intervalo;
    logic                cand_ok;
    logic                acerto_jogada;
    logic [CW-1:0]       rodada_inc;

    assign lfsr_passo        = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? TAPS : 16'h0000);
    assign semente           = (livre_reg == 16'h0000) ? 16'h0001 : livre_reg;
    assign cand              = lfsr_passo[IW-1:0];
    assign cand_no_intervalo = {1'b0, cand} < N_LIM;
    assign acerto_jogada     = (jogada_reg == alvo_reg);
    assign rodada_inc        = rodada_reg + CW'(1);

`ifdef SEM_REPETICAO_EN
    logic [IW-1:0] ant_reg;
    logic          repete;
    // The first round of a game has no previous target to compare against
    assign repete  = (N_BOTOES > 1) && (rodada_reg != '0) && (cand == ant_reg);
    assign cand_ok = cand_no_intervalo && !repete;
`else
    assign cand_ok = cand_no_intervalo;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_BOTOES; gi++) begin : g_dec_alvo
            assign cand_onehot[gi] = (cand == IW'(gi));
        end
    endgenerate

    always_comb begin
        estado_next     = estado_reg;
        carrega_semente = 1'b0;
        avanca_lfsr     = 1'b0;
        aceita          = 1'b0;
        limpa_tempo     = 1'b0;
        conta_tempo     = 1'b0;
        captura_jogada  = 1'b0;
        marca_timeout   = 1'b0;
        pontua          = 1'b0;
        case (estado_reg)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    carrega_semente = 1'b1;
                    estado_next     = SORTEIA;
                end
            end
            SORTEIA: begin
                avanca_lfsr = 1'b1;
                if (cand_ok) begin
                    aceita      = 1'b1;
                    estado_next = ESPERA_SOLTA;
                end
            end
            ESPERA_SOLTA: begin
                if (botoes_reg == '0) begin
                    limpa_tempo = 1'b1;
                    estado_next = ESPERA_JOGADA;
                end
            end
            ESPERA_JOGADA: begin
                conta_tempo = 1'b1;
                // A press in the final timeout cycle still counts as a press
                if (botoes_reg != '0) begin
                    captura_jogada = 1'b1;
                    estado_next    = AVALIA;
                end else if (tempo_reg == TW'(TIMEOUT - 1)) begin
                    marca_timeout = 1'b1;
                    estado_next   = AVALIA;
                end
            end
            AVALIA: begin
                pontua      = 1'b1;
                estado_next = (rodada_inc == CW'(RODADAS)) ? FIM : SORTEIA;
            end
            default: estado_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg     <= OCIOSO;
            livre_reg      <= '0;
            lfsr_reg       <= '0;
            botoes_reg     <= '0;
            alvo_reg       <= '0;
            jogada_reg     <= '0;
            tipo_press_reg <= 1'b0;
            tempo_reg      <= '0;
            rodada_reg     <= '0;
            acertos_reg    <= '0;
            erros_reg      <= '0;
            timeouts_reg   <= '0;
`ifdef SEM_REPETICAO_EN
            ant_reg        <= '0;
`endif
        end else begin
            estado_reg <= estado_next;
            livre_reg  <= livre_reg + 16'd1;
            botoes_reg <= botoes;

            if (carrega_semente) begin
                lfsr_reg     <= semente;
                rodada_reg   <= '0;
                acertos_reg  <= '0;
                erros_reg    <= '0;
                timeouts_reg <= '0;
            end else if (avanca_lfsr) begin
                lfsr_reg <= lfsr_passo;
            end

            if (aceita) begin
                alvo_reg <= cand_onehot;
`ifdef SEM_REPETICAO_EN
                ant_reg  <= cand;
`endif
            end

            if (limpa_tempo) begin
                tempo_reg <= '0;
            end else if (conta_tempo) begin
                tempo_reg <= tempo_reg + TW'(1);
            end

            if (captura_jogada) begin
                jogada_reg     <= botoes_reg;
                tipo_press_reg <= 1'b1;
            end else if (marca_timeout) begin
                tipo_press_reg <= 1'b0;
            end

            if (pontua) begin
                rodada_reg <= rodada_inc;
                if (!tipo_press_reg) begin
                    timeouts_reg <= timeouts_reg + CW'(1);
                end else if (acerto_jogada) begin
                    acertos_reg <= acertos_reg + CW'(1);
                end else begin
                    erros_reg <= erros_reg + CW'(1);
                end
            end
        end
    end

    assign alvo_valido  = (estado_reg == ESPERA_SOLTA) || (estado_reg == ESPERA_JOGADA);
    assign alvo         = alvo_valido ? alvo_reg : '0;
    assign jogada_feita = (estado_reg == AVALIA) && tipo_press_reg;
    assign acerto_pulso = jogada_feita && acerto_jogada;
    assign pronto       = (estado_reg == FIM);
    assign rodada       = rodada_reg;
    assign acertos      = acertos_reg;
    assign erros        = erros_reg;
    assign timeouts     = timeouts_reg;
    assign db_estado    = estado_reg;
    assign db_lfsr      = lfsr_reg;

endmodule
